// File: rtl/traffic_intersection_ctrl_if.sv
// ---------------------------------------------------------------------------
// traffic_intersection_ctrl_if
//   Board-side signal bundle for the two-approach intersection controller.
//
//   Signals
//     ped_req   pedestrian request button (synchronous level or pulse)
//     flash_en  night-mode switch (acted on at prescaler ticks only)
//     ns_r/ns_y/ns_g, ew_r/ew_y/ew_g   approach lamps
//     walk      pedestrian walk lamp
//     ped_pend  a pedestrian request is latched and not yet served
//     phase     controller state code, for debug and checkers
//
//   Handshake: there is no valid/ready pair on this bundle. Inputs are plain
//   levels sampled on clk_50; outputs are Moore levels that change only on
//   the clk_50 edge that updates the controller state.
//
//   Modports
//     slave   the controller (consumes switches, drives lamps)
//     master  the board / testbench side
// ---------------------------------------------------------------------------
interface traffic_intersection_ctrl_if;
  logic       ped_req;
  logic       flash_en;
  logic       ns_r;
  logic       ns_y;
  logic       ns_g;
  logic       ew_r;
  logic       ew_y;
  logic       ew_g;
  logic       walk;
  logic       ped_pend;
  logic [2:0] phase;

  modport slave (
    input  ped_req,
    input  flash_en,
    output ns_r,
    output ns_y,
    output ns_g,
    output ew_r,
    output ew_y,
    output ew_g,
    output walk,
    output ped_pend,
    output phase
  );

  modport master (
    output ped_req,
    output flash_en,
    input  ns_r,
    input  ns_y,
    input  ns_g,
    input  ew_r,
    input  ew_y,
    input  ew_g,
    input  walk,
    input  ped_pend,
    input  phase
  );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_intersection_ctrl
//   Two-approach (NS/EW) intersection controller. A free-running prescaler
//   produces a one-cycle tick every TICK_DIV clocks; all phase timing is
//   counted in ticks. Sequence: green -> yellow -> all-red clearance ->
//   (optional pedestrian walk) -> other approach's green. A night mode
//   flashes both yellows.
//
//   Ports
//     clk_50  system clock
//     rst_n   asynchronous reset, active low
//     bus     traffic_intersection_ctrl_if.slave (switch inputs, lamps,
//             ped_pend and the debug phase code)
//
//   Phase codes: 0 NS_GREEN, 1 NS_YEL, 2 ALL_RED, 3 EW_GREEN, 4 EW_YEL,
//                5 WALK, 6 FLASH.
// ---------------------------------------------------------------------------
module traffic_intersection_ctrl #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int GREEN_TICKS   = 5,
  parameter int YELLOW_TICKS  = 2,
  parameter int ALL_RED_TICKS = 1,
  parameter int WALK_TICKS    = 4,
  parameter int TIMER_W       = 8
) (
  input logic                        clk_50,
  input logic                        rst_n,
  traffic_intersection_ctrl_if.slave bus
);

  localparam logic [2:0] S_NS_GREEN = 3'd0;
  localparam logic [2:0] S_NS_YEL   = 3'd1;
  localparam logic [2:0] S_ALL_RED  = 3'd2;
  localparam logic [2:0] S_EW_GREEN = 3'd3;
  localparam logic [2:0] S_EW_YEL   = 3'd4;
  localparam logic [2:0] S_WALK     = 3'd5;
  localparam logic [2:0] S_FLASH    = 3'd6;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  // Timers hold D-1 so a state lasts exactly D ticks (exit on timer==0).
  localparam logic [TIMER_W-1:0] GREEN_LOAD   = TIMER_W'(GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LOAD  = TIMER_W'(YELLOW_TICKS - 1);
  localparam logic [TIMER_W-1:0] ALL_RED_LOAD = TIMER_W'(ALL_RED_TICKS - 1);
  localparam logic [TIMER_W-1:0] WALK_LOAD    = TIMER_W'(WALK_TICKS - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [2:0]         state,     state_nxt;
  logic [TIMER_W-1:0] timer,     timer_nxt;
  logic               next_dir,  next_dir_nxt;
  logic               flash_ph,  flash_ph_nxt;
  logic               ped_pend;
  logic               ped_clr;

  // -------------------------------------------------------------------------
  // Tick prescaler
  // -------------------------------------------------------------------------
  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Everything here only moves on a tick; between ticks
  // the state, timer, direction and flash phase hold.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    next_dir_nxt = next_dir;
    flash_ph_nxt = flash_ph;
    ped_clr      = 1'b0;

    if (tick) begin
      if (state == S_FLASH) begin
        if (bus.flash_en) begin
          flash_ph_nxt = ~flash_ph;
        end else begin
          // Leaving night mode restarts the cycle from a clean clearance.
          state_nxt    = S_ALL_RED;
          timer_nxt    = ALL_RED_LOAD;
          next_dir_nxt = DIR_NS;
          ped_clr      = 1'b1;
        end
      end else if (bus.flash_en) begin
        // Night mode overrides whatever the timer is doing.
        state_nxt    = S_FLASH;
        flash_ph_nxt = 1'b1;
      end else if (timer == '0) begin
        case (state)
          S_NS_GREEN: begin
            state_nxt = S_NS_YEL;
            timer_nxt = YELLOW_LOAD;
          end
          S_NS_YEL: begin
            state_nxt    = S_ALL_RED;
            timer_nxt    = ALL_RED_LOAD;
            next_dir_nxt = DIR_EW;
          end
          S_EW_GREEN: begin
            state_nxt = S_EW_YEL;
            timer_nxt = YELLOW_LOAD;
          end
          S_EW_YEL: begin
            state_nxt    = S_ALL_RED;
            timer_nxt    = ALL_RED_LOAD;
            next_dir_nxt = DIR_NS;
          end
          S_ALL_RED: begin
            if (ped_pend) begin
              state_nxt = S_WALK;
              timer_nxt = WALK_LOAD;
              ped_clr   = 1'b1;
            end else begin
              state_nxt = (next_dir == DIR_EW) ? S_EW_GREEN : S_NS_GREEN;
              timer_nxt = GREEN_LOAD;
            end
          end
          S_WALK: begin
            state_nxt = (next_dir == DIR_EW) ? S_EW_GREEN : S_NS_GREEN;
            timer_nxt = GREEN_LOAD;
          end
          default: begin
            // Unused code: recover through a clearance phase.
            state_nxt = S_ALL_RED;
            timer_nxt = ALL_RED_LOAD;
          end
        endcase
      end else begin
        timer_nxt = timer - TIMER_ONE;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_ALL_RED;
      timer    <= ALL_RED_LOAD;
      next_dir <= DIR_NS;
      flash_ph <= 1'b1;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      next_dir <= next_dir_nxt;
      flash_ph <= flash_ph_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Pedestrian request latch. A request on the same cycle as WALK entry
  // wins over the clear, so it is served on the next round. Requests are
  // not latched while flashing.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend <= 1'b0;
    end else if (bus.ped_req && (state != S_FLASH)) begin
      ped_pend <= 1'b1;
    end else if (ped_clr) begin
      ped_pend <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Moore lamp decode from the registered state
  // -------------------------------------------------------------------------
  always_comb begin
    bus.ns_r = 1'b0;
    bus.ns_y = 1'b0;
    bus.ns_g = 1'b0;
    bus.ew_r = 1'b0;
    bus.ew_y = 1'b0;
    bus.ew_g = 1'b0;
    bus.walk = 1'b0;
    case (state)
      S_NS_GREEN: begin bus.ns_g = 1'b1; bus.ew_r = 1'b1; end
      S_NS_YEL:   begin bus.ns_y = 1'b1; bus.ew_r = 1'b1; end
      S_EW_GREEN: begin bus.ew_g = 1'b1; bus.ns_r = 1'b1; end
      S_EW_YEL:   begin bus.ew_y = 1'b1; bus.ns_r = 1'b1; end
      S_WALK: begin
        bus.ns_r = 1'b1;
        bus.ew_r = 1'b1;
        bus.walk = 1'b1;
      end
      S_FLASH: begin
        bus.ns_y = flash_ph;
        bus.ew_y = flash_ph;
      end
      default: begin
        bus.ns_r = 1'b1;
        bus.ew_r = 1'b1;
      end
    endcase
  end

  assign bus.ped_pend = ped_pend;
  assign bus.phase    = state;

endmodule
